jk_pattern_driver: RTL and testbench
====================================

Name: jk_pattern_driver

Overview:
- Driver-side companion to the JK flip-flop. It accepts a bit pattern and steers an external jk_flipflop through it, one target bit per clock, LSB first.
- Per cycle, J/K come from the JK excitation table, using the flop's actual Q (q_in) and the next target bit.
- Optionally self-checks Q one cycle later and counts mismatches.
- Used as the reusable stimulus and checker engine for JK-based blocks and benches.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- LEN_W, 5, width of len; must hold WIDTH.
- CNT_W, 4, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock; shared with the driven flop.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to run a pattern; accepted only in IDLE.
- pat  input  WIDTH  target Q sequence; bit 0 is driven first; sampled on accept.
- len  input  LEN_W  number of bits to drive; sampled on accept.
- q_in  input  1  Q of the driven jk_flipflop.
- J  output  1  J drive to the flop.
- K  output  1  K drive to the flop.
- busy  output  1  high in RUN and LAST.
- done  output  1  one-cycle pulse when a run completes.
- mismatch  output  1  one-cycle pulse on a Q compare failure.
- err_cnt  output  CNT_W  mismatches in the current or last run.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; J=K=0; busy=done=mismatch=0; err_cnt=0; idx=0.
  - Reset mid-run aborts immediately: no done pulse, J/K drop to 0 asynchronously.
- States: IDLE, RUN, LAST.
- IDLE:
  - J=K=0.
  - When start=1, on the edge: pat_r<=pat; n_r<=min(len,WIDTH); idx<=0; err_cnt<=0.
  - If n_r would be 0: stay IDLE and pulse done next cycle; no bits driven.
  - Otherwise go to RUN.
- RUN:
  - d=pat_r[idx]. J/K are combinational from q_in and d:
    - q_in=0, d=0 -> J=0, K=0
    - q_in=0, d=1 -> J=1, K=0
    - q_in=1, d=0 -> J=0, K=1
    - q_in=1, d=1 -> J=0, K=0
  - Don't-cares are resolved to 0; the toggle state J=K=1 is never driven.
  - Each edge: exp<=d; chk_v<=1; idx<=idx+1.
  - When idx=n_r-1 on the edge, go to LAST.
- LAST:
  - J=K=0 (hold).
  - On the edge: final compare, done<=1 for one cycle, state<=IDLE.
- Latency:
  - Bit i reaches Q at the (i+1)th edge after accept.
  - done is high for the cycle following LAST.
  - Total busy cycles = n_r+1.
- Compare:
  - On every edge in RUN (after the first) and in LAST, if chk_v=1 and q_in!=exp: mismatch<=1 for one cycle and err_cnt<=err_cnt+1.
  - err_cnt saturates at 2^CNT_W-1.
  - chk_v clears on entry to IDLE.
- Start handling:
  - start while busy is ignored (no queueing).
  - start in the same cycle as done/IDLE re-entry is accepted.
- Pattern and length are frozen while busy; changes to pat/len during a run have no effect.
- q_in is closed-loop: a flop upset is corrected on the next bit. The excitation uses actual Q, not the expected value.

Optional Feature:
- Macro: JK_PATTERN_SELFCHECK_EN.
- Defined: compare logic, mismatch, and err_cnt are implemented as described.
- Undefined: mismatch and err_cnt are tied to 0, the compare registers are removed, and J/K/busy/done timing is unchanged.

Test Plan:
- Reset mid-run:
  - Stimulus: rst=1 for 2 cycles, then start with pat=16'hA5A5 and len=16; assert rst after 5 bits.
  - Required: J=K=0, busy=0, err_cnt=0 immediately; no done pulse.
- Basic pattern:
  - Stimulus: flop Q=0, pat=4'b1011, len=4.
  - Required: Q sequence 1,1,0,1 on edges 1..4; J/K per cycle = (1,0),(0,0),(0,1),(1,0); done at cycle 6; err_cnt=0.
- Length clamp and zero length:
  - Stimulus: len=31 with WIDTH=16; then len=0.
  - Required: len=31 gives exactly 16 bits and 17 busy cycles; len=0 gives busy never high and a done pulse one cycle after start.
- Fault injection:
  - Stimulus: bench forces q_in=0 for one cycle while exp=1, with pat=8'hFF and len=8.
  - Required: mismatch pulses once; err_cnt=1; the following bits recover with J=1; done still asserts.
- Saturation:
  - Stimulus: CNT_W=4; q_in held stuck at 0; pat=16'hFFFF; len=16.
  - Required: err_cnt stops at 15; mismatch pulses 16 times.
- Start while busy and back-to-back:
  - Stimulus: start pulsed while busy; then start asserted in the done cycle.
  - Required: the first pulse is ignored; the done-cycle start begins a new run with err_cnt cleared.

Source files
------------

// File: rtl/jk_pattern_driver.sv
// Steers an external JK flop through a stored pattern, LSB first, via the excitation table on live Q; self-check under JK_PATTERN_SELFCHECK_EN.
// Latency: bit i lands in Q at edge i+1 after accept, done one cycle after LAST; start is ignored (not queued) while busy.
module jk_pattern_driver #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic             q_in,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] n_q, n_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamped;
    logic [WIDTH-1:0] pat_sh;
    logic             d_bit;

    assign len_clamped = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign pat_sh      = pat_q >> idx_q;
    assign d_bit       = pat_sh[0];

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        n_d     = n_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        J       = 1'b0;
        K       = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d = pat;
                    n_d   = len_clamped;
                    idx_d = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                // Excitation from actual Q; J=K=1 is never produced.
                J     = ~q_in & d_bit;
                K     = q_in & ~d_bit;
                idx_d = idx_q + LEN_W'(1);
                if (idx_q == n_q - LEN_W'(1)) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                busy    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

`ifdef JK_PATTERN_SELFCHECK_EN
    logic             exp_q, exp_d;
    logic             chk_v_q, chk_v_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        exp_d      = exp_q;
        chk_v_d    = chk_v_q;
        mismatch_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                chk_v_d = 1'b0;
                if (start) begin
                    err_cnt_d = '0;
                end
            end
            RUN: begin
                exp_d   = d_bit;
                chk_v_d = 1'b1;
            end
            default: chk_v_d = 1'b0;
        endcase
        // Q is compared one edge after the bit was driven.
        if ((state_q != IDLE) && chk_v_q && (q_in != exp_q)) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= 1'b0;
            chk_v_q    <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            exp_q      <= exp_d;
            chk_v_q    <= chk_v_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
`else
    assign mismatch = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench for jk_pattern_driver closed-loop with a behavioural JK flop.
// Mismatch/err_cnt expectations follow JK_PATTERN_SELFCHECK_EN.
module tb_jk_pattern_driver;
    localparam int WIDTH = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 4;
`ifdef JK_PATTERN_SELFCHECK_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             q_in;
    logic             J;
    logic             K;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;

    logic q_flop;
    logic force_en;
    int   n_tests;
    int   n_fail;

    jk_pattern_driver #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pat      (pat),
        .len      (len),
        .q_in     (q_in),
        .J        (J),
        .K        (K),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign q_in = force_en ? 1'b0 : q_flop;

    always @(posedge clk or posedge rst) begin
        if (rst) q_flop <= 1'b0;
        else begin
            case ({J, K})
                2'b10:   q_flop <= 1'b1;
                2'b01:   q_flop <= 1'b0;
                2'b11:   q_flop <= ~q_flop;
                default: q_flop <= q_flop;
            endcase
        end
    end

    task automatic apply_reset();
        rst      = 1'b1;
        start    = 1'b0;
        force_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after accept.
    task automatic do_start(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l);
        start = 1'b1;
        pat   = p;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        pat   = ~p;
        len   = 5'd7;
    endtask

    task automatic test_reset();
        int done_cnt;
        int busy_cnt;
        n_tests++;
        if ({J, K, busy, done, mismatch, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0", {J, K, busy, done, mismatch, err_cnt});
        end
        do_start(16'hA5A5, 5'd16);
        repeat (5) @(negedge clk);
        n_tests++;
        if ({J, K, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL midrun_pre: got JKbusy=%b expected 101", {J, K, busy});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({J, K, busy, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midrun_abort: got JKbusy=%b err=%0d expected 0", {J, K, busy}, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            n_fail++;
            $display("FAIL midrun_nodone: got done=%0d busy=%0d expected 0 0", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;
        ej = 4'b1001;
        ek = 4'b0100;
        eq = 4'b1011;
        apply_reset();
        do_start(16'h000B, 5'd4);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({J, K, busy} !== {ej[i], ek[i], 1'b1}) begin
                n_fail++;
                $display("FAIL basic_jk%0d: got JKbusy=%b expected %b", i, {J, K, busy}, {ej[i], ek[i], 1'b1});
            end
            @(negedge clk);
            n_tests++;
            if (q_flop !== eq[i]) begin
                n_fail++;
                $display("FAIL basic_q%0d: got %b expected %b", i, q_flop, eq[i]);
            end
        end
        n_tests++;
        if ({busy, J, K, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_last: got busyJKdone=%b expected 1000", {busy, J, K, done});
        end
        @(negedge clk);
        n_tests++;
        if ({busy, done, err_cnt} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL basic_done: got busy=%b done=%b err=%0d expected 0 1 0", busy, done, err_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_len_clamp();
        int busy_cnt;
        int done_cnt;
        apply_reset();
        do_start(16'hC3A5, 5'd31);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (busy_cnt != 17 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL clamp_busy: got busy=%0d done=%0d expected 17 1", busy_cnt, done_cnt);
        end
        n_tests++;
        if (q_flop !== 1'b1 || err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clamp_final: got q=%b err=%0d expected 1 0", q_flop, err_cnt);
        end
    endtask

    task automatic test_zero_len();
        int busy_cnt;
        apply_reset();
        do_start(16'hFFFF, 5'd0);
        n_tests++;
        if ({busy, done, J, K} !== 4'b0100) begin
            n_fail++;
            $display("FAIL zero_done: got busy done J K=%b expected 0100", {busy, done, J, K});
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse: got %b expected 0", done);
        end
        busy_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (busy_cnt != 0 || q_flop !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: got busy=%0d q=%b expected 0 0", busy_cnt, q_flop);
        end
    endtask

    task automatic test_fault_inject();
        int mm_cnt;
        int done_cnt;
        int busy_cnt;
        apply_reset();
        do_start(16'h00FF, 5'd8);
        mm_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            force_en = (c == 3);
            #1;
            if (c == 3) begin
                n_tests++;
                if ({J, K} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL fault_recover_j: got JK=%b expected 10", {J, K});
                end
            end
            if (c == 4) begin
                n_tests++;
                if (mismatch !== SC[0]) begin
                    n_fail++;
                    $display("FAIL fault_mm_time: got %b expected %b", mismatch, SC[0]);
                end
            end
            if (mismatch) mm_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        force_en = 1'b0;
        n_tests++;
        if (mm_cnt != SC || err_cnt !== CNT_W'(SC)) begin
            n_fail++;
            $display("FAIL fault_count: got mm=%0d err=%0d expected %0d %0d", mm_cnt, err_cnt, SC, SC);
        end
        n_tests++;
        if (done_cnt != 1 || busy_cnt != 9 || q_flop !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_run: got done=%0d busy=%0d q=%b expected 1 9 1", done_cnt, busy_cnt, q_flop);
        end
    endtask

    task automatic test_saturation();
        int mm_cnt;
        int j_cnt;
        int busy_cnt;
        apply_reset();
        force_en = 1'b1;
        do_start(16'hFFFF, 5'd16);
        mm_cnt = 0;
        j_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (mismatch) mm_cnt++;
            if (J) j_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        force_en = 1'b0;
        n_tests++;
        if (mm_cnt != 16 * SC) begin
            n_fail++;
            $display("FAIL sat_mm: got %0d expected %0d", mm_cnt, 16 * SC);
        end
        n_tests++;
        if (err_cnt !== CNT_W'(15 * SC)) begin
            n_fail++;
            $display("FAIL sat_err: got %0d expected %0d", err_cnt, 15 * SC);
        end
        n_tests++;
        if (j_cnt != 16 || busy_cnt != 17) begin
            n_fail++;
            $display("FAIL sat_drive: got J=%0d busy=%0d expected 16 17", j_cnt, busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        int done_cnt;
        int b2b_c;
        apply_reset();
        do_start(16'h0006, 5'd4);
        busy_cnt = 0;
        done_cnt = 0;
        b2b_c = -10;
        for (int c = 0; c < 16; c++) begin
            start = 1'b0;
            force_en = (c == 2);
            if (c == 1) begin
                start = 1'b1;
                pat   = 16'hFFFF;
                len   = 5'd10;
            end
            #1;
            if (busy) busy_cnt++;
            if (c == b2b_c + 1) begin
                n_tests++;
                if (busy !== 1'b1 || err_cnt !== 4'd0) begin
                    n_fail++;
                    $display("FAIL b2b_accept: got busy=%b err=%0d expected 1 0", busy, err_cnt);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    n_tests++;
                    if (c != 5 || q_flop !== 1'b0 || err_cnt !== CNT_W'(SC)) begin
                        n_fail++;
                        $display("FAIL b2b_first: got cyc=%0d q=%b err=%0d expected 5 0 %0d", c, q_flop, err_cnt, SC);
                    end
                    start = 1'b1;
                    pat   = 16'h0005;
                    len   = 5'd3;
                    b2b_c = c;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        force_en = 1'b0;
        n_tests++;
        if (busy_cnt != 9 || done_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got busy=%0d done=%0d expected 9 2", busy_cnt, done_cnt);
        end
        n_tests++;
        if (q_flop !== 1'b1 || err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_final: got q=%b err=%0d expected 1 0", q_flop, err_cnt);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        pat      = '0;
        len      = '0;
        force_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_len_clamp();
        test_zero_len();
        test_fault_inject();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
